// File: rtl/demux1_8_reg.sv
// Registered 1-to-8 demultiplexer with manual or auto-incrementing slot select.
// It tracks which slots have been written in a frame, pulses frame_valid when all 8 are written, and pulses overrun when a slot is rewritten.
module demux1_8_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [2:0] sel,
  input  logic       en,
  input  logic       auto,
  output logic [7:0] out,
  output logic [2:0] cur_sel,
  output logic       frame_valid,
  output logic       overrun,
  output logic       dbg_state,
  output logic [7:0] dbg_mask,
  output logic [2:0] dbg_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_mask;
  logic       r_auto_q;

  logic       w_auto_rise;
  logic [2:0] w_cnt_eff;
  logic [2:0] w_slot;
  logic [7:0] w_slot_oh;
  logic [7:0] w_mask_eff;
  logic [7:0] w_mask_new;

  // Entering auto mode starts a fresh frame at slot 0, in the same cycle as the first auto write.
  assign w_auto_rise = auto & ~r_auto_q;
  assign w_cnt_eff   = w_auto_rise ? 3'd0 : r_cnt;
  assign w_mask_eff  = w_auto_rise ? 8'h00 : r_mask;
  assign w_slot      = auto ? w_cnt_eff : sel;
  assign w_slot_oh   = 8'b0000_0001 << w_slot;
  assign w_mask_new  = w_mask_eff | w_slot_oh;

  assign dbg_state = r_state;
  assign dbg_mask  = r_mask;
  assign dbg_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= 8'h00;
      cur_sel     <= 3'd0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_mask      <= 8'h00;
      r_auto_q    <= 1'b0;
    end else begin
      r_auto_q    <= auto;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      if (en) begin
        out[w_slot] <= din;
        cur_sel     <= w_slot;
        if (auto) r_cnt <= w_cnt_eff + 3'd1;
        overrun <= |(w_mask_eff & w_slot_oh);
        if (&w_mask_new) begin
          frame_valid <= 1'b1;
          r_mask      <= 8'h00;
          r_state     <= S_IDLE;
        end else begin
          r_mask  <= w_mask_new;
          r_state <= S_FILL;
        end
      end else if (w_auto_rise) begin
        r_cnt   <= 3'd0;
        r_mask  <= 8'h00;
        r_state <= S_IDLE;
      end
    end
  end

endmodule
